// File: rtl/shift_pipelined_param.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with one power-of-two shift step per
// registered stage and valid/ready flow control on both sides.
module shift_pipelined_param #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [SHAMT_W-1:0] stage_valid;
    logic [SHAMT_W-1:0] adv;

    // Advance chain is combinational back from out_ready; there is no skid buffer.
    always_comb begin
        adv = '0;
        adv[SHAMT_W-1] = !stage_valid[SHAMT_W-1] || out_ready;
        for (int k = SHAMT_W - 2; k >= 0; k--) begin
            adv[k] = !stage_valid[k] || adv[k+1];
        end
    end

    assign in_ready = reset_n && adv[0];

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int AMT = 1 << gi;
            // Each stage only carries the shift bits still to be applied downstream.
            localparam int RW  = SHAMT_W - gi;

            logic               src_valid;
            logic [WIDTH-1:0]   src_data;
            logic [RW-1:0]      src_shamt;
            logic [1:0]         src_op;
            logic [TAG_W-1:0]   src_tag;
            logic               valid_q;
            logic [WIDTH-1:0]   data_q;
            logic [WIDTH-1:0]   data_d;
            logic [TAG_W-1:0]   tag_q;

            if (gi == 0) begin : g_head
                assign src_valid = in_valid;
                assign src_data  = in_data;
                assign src_shamt = in_shamt;
                assign src_op    = in_op;
                assign src_tag   = in_tag;
            end else begin : g_body
                assign src_valid = g_stage[gi-1].valid_q;
                assign src_data  = g_stage[gi-1].data_q;
                assign src_shamt = g_stage[gi-1].g_fwd.rem_q;
                assign src_op    = g_stage[gi-1].g_fwd.op_q;
                assign src_tag   = g_stage[gi-1].tag_q;
            end

            always_comb begin
                data_d = src_data;
                if (src_shamt[0]) begin
                    case (src_op)
                        OP_SLL:  data_d = {src_data[WIDTH-1-AMT:0], {AMT{1'b0}}};
                        OP_SRL:  data_d = {{AMT{1'b0}}, src_data[WIDTH-1:AMT]};
                        OP_SRA:  data_d = {{AMT{src_data[WIDTH-1]}}, src_data[WIDTH-1:AMT]};
                        default: data_d = {src_data[AMT-1:0], src_data[WIDTH-1:AMT]};
                    endcase
                end
            end

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    tag_q   <= '0;
                end else if (adv[gi]) begin
                    valid_q <= src_valid;
                    if (src_valid) begin
                        data_q <= data_d;
                        tag_q  <= src_tag;
                    end
                end
            end

            if (gi < SHAMT_W - 1) begin : g_fwd
                logic [RW-2:0] rem_q;
                logic [1:0]    op_q;

                always_ff @(posedge clock) begin
                    if (!reset_n) begin
                        rem_q <= '0;
                        op_q  <= '0;
                    end else if (adv[gi] && src_valid) begin
                        rem_q <= src_shamt[RW-1:1];
                        op_q  <= src_op;
                    end
                end
            end

            assign stage_valid[gi] = valid_q;
        end
    endgenerate

    assign out_valid = g_stage[SHAMT_W-1].valid_q;
    assign out_data  = g_stage[SHAMT_W-1].data_q;
    assign out_tag   = g_stage[SHAMT_W-1].tag_q;
endmodule

// File: tb/tb_shift_pipelined_param.sv
// Directed bench for shift_pipelined_param: a 32-bit instance for latency, throughput,
// backpressure and reset, plus an 8-bit instance with a reference-model scoreboard.
module tb_shift_pipelined_param;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt, in_tag, out_tag;
    logic [1:0]  in_op;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    logic [2:0] b_in_shamt;
    logic [1:0] b_in_op, b_in_tag, b_out_tag;

    int checks   = 0;
    int failures = 0;

    shift_pipelined_param #(.WIDTH(32), .TAG_W(5)) dut32 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    shift_pipelined_param #(.WIDTH(8), .TAG_W(2)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_op(b_in_op), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_tag(b_out_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] op, input logic [4:0] t);
        in_valid = v;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        in_tag   = t;
    endtask

    // Accept one op, then expect it on the output exactly five edges after acceptance.
    task automatic single_op(input string name, input logic [31:0] d, input logic [4:0] s,
                             input logic [1:0] op, input logic [4:0] t, input logic [31:0] exp);
        drive(1'b1, d, s, op, t);
        tick();
        drive(1'b0, 32'h0, 5'd0, 2'd0, 5'd0);
        repeat (3) tick();
        check({name, "_early"}, 64'(out_valid), 64'd0);
        tick();
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_data"}, 64'(out_data), 64'(exp));
        check({name, "_tag"}, 64'(out_tag), 64'(t));
        tick();
        check({name, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    function automatic logic [7:0] ref8(input logic [7:0] d, input logic [2:0] s,
                                        input logic [1:0] op);
        logic signed [7:0] sd;
        logic [15:0]       dd;
        sd = d;
        dd = {d, d};
        case (op)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return sd >>> s;
            default: return 8'(dd >> s);
        endcase
    endfunction

    logic [9:0] sb[$];
    logic [9:0] ent;
    int recv, first, acc, stale, sent, got;

    initial begin
        reset_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 2'd0, 5'd0);
        b_in_valid = 1'b0; b_in_data = 8'h0; b_in_shamt = 3'd0; b_in_op = 2'd0; b_in_tag = 2'd0;
        b_out_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Single-op latency and operation checks
        single_op("sra31", 32'h8000_0000, 5'd31, 2'b10, 5'd3, 32'hFFFF_FFFF);
        single_op("ror4", 32'h1234_5678, 5'd4, 2'b11, 5'd7, 32'h8123_4567);
        single_op("srl1", 32'h8000_0000, 5'd1, 2'b01, 5'd9, 32'h4000_0000);
        single_op("sll0", 32'hDEAD_BEEF, 5'd0, 2'b00, 5'd1, 32'hDEAD_BEEF);
        single_op("sra_pos", 32'h7000_0000, 5'd28, 2'b10, 5'd2, 32'h0000_0007);

        // Back-to-back SLL 1 by 0..31 at full throughput
        recv = 0;
        first = -1;
        for (int c = 0; c < 40; c++) begin
            if (c < 32) begin
                drive(1'b1, 32'h1, c[4:0], 2'b00, c[4:0]);
                #1;
                check("b2b_in_ready", 64'(in_ready), 64'd1);
            end else begin
                drive(1'b0, 32'h0, 5'd0, 2'd0, 5'd0);
            end
            tick();
            if (out_valid) begin
                if (first < 0) first = c;
                check("b2b_data", 64'(out_data), 64'(32'h1 << recv));
                check("b2b_tag", 64'(out_tag), 64'(recv[4:0]));
                recv++;
            end
        end
        check("b2b_count", 64'(recv), 64'd32);
        check("b2b_latency", 64'(first), 64'd4);

        // Backpressure: fill, stall, then drain
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 32'(acc + 1), 5'd4, 2'b00, 5'(acc + 10));
            #1;
            if (c >= 5) check("bp_in_ready_low", 64'(in_ready), 64'd0);
            if (out_valid) begin
                check("bp_hold_data", 64'(out_data), 64'h10);
                check("bp_hold_tag", 64'(out_tag), 64'd10);
            end
            if (in_ready) acc++;
            tick();
        end
        check("bp_accepts", 64'(acc), 64'd5);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 32'h0, 5'd0, 2'd0, 5'd0);
        out_ready = 1'b1;
        recv = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                check("bp_drain_data", 64'(out_data), 64'((recv + 1) << 4));
                check("bp_drain_tag", 64'(out_tag), 64'(recv + 10));
                recv++;
            end
            tick();
        end
        check("bp_drain_count", 64'(recv), 64'd5);

        // Reset with three ops in flight
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'hA5A5_0000 + 32'(c), 5'(c), 2'b01, 5'(c + 20));
            tick();
        end
        drive(1'b0, 32'h0, 5'd0, 2'd0, 5'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        reset_n = 1'b1;
        #1;
        check("mid_rel_in_ready", 64'(in_ready), 64'd1);
        stale = 0;
        repeat (8) begin
            tick();
            if (out_valid) stale++;
        end
        check("mid_rst_stale", 64'(stale), 64'd0);

        // 8-bit instance: directed SRA, latency 3
        b_in_valid = 1'b1; b_in_data = 8'h90; b_in_shamt = 3'd3; b_in_op = 2'b10; b_in_tag = 2'd2;
        tick();
        b_in_valid = 1'b0;
        tick();
        check("w8_early", 64'(b_out_valid), 64'd0);
        tick();
        check("w8_valid", 64'(b_out_valid), 64'd1);
        check("w8_sra_data", 64'(b_out_data), 64'hF2);
        check("w8_sra_tag", 64'(b_out_tag), 64'd2);
        tick();

        // 8-bit instance: random traffic and backpressure against the reference model
        sent = 0;
        got = 0;
        for (int c = 0; c < 2000; c++) begin
            b_in_valid  = (c < 1900) && ($urandom_range(0, 3) != 0);
            b_out_ready = (c >= 1900) || ($urandom_range(0, 3) != 0);
            b_in_data   = 8'($urandom);
            b_in_shamt  = 3'($urandom_range(0, 7));
            b_in_op     = 2'($urandom_range(0, 3));
            b_in_tag    = 2'($urandom_range(0, 3));
            #1;
            if (b_out_valid && b_out_ready) begin
                if (sb.size() == 0) begin
                    check("w8_spurious", 64'(b_out_valid), 64'd0);
                end else begin
                    ent = sb.pop_front();
                    check("w8_rand_data", 64'(b_out_data), 64'(ent[7:0]));
                    check("w8_rand_tag", 64'(b_out_tag), 64'(ent[9:8]));
                end
                got++;
            end
            if (b_in_valid && b_in_ready) begin
                sb.push_back({b_in_tag, ref8(b_in_data, b_in_shamt, b_in_op)});
                sent++;
            end
            tick();
        end
        check("w8_rand_count", 64'(got), 64'(sent));
        check("w8_rand_left", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
